gelato_fetch_arbiter: RTL and testbench
=======================================

GELATO_FETCH_ARBITER -- requirements
Module: gelato_fetch_arbiter

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warp slots (power of two, >=2).
REQ-002 SHALL have parameter PC_WIDTH, default 32, PC width in bits.
REQ-003 SHALL have parameter SCHED_MODE, default 0; 0 = round-robin, 1 = greedy-then-oldest (GTO).
REQ-004 SHALL have parameter AGE_WIDTH, default 8, per-warp saturating age counter width.
REQ-005 SHALL use WID = log2(NUM_WARPS) for all warp-id ports.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 rdy  in  1  global enable; low freezes all state.
REQ-009 act_valid / act_warp / act_pc  in  1 / WID / PC_WIDTH  warp activation from split table.
REQ-010 req_valid  out  1; req_ready  in  1; req_warp  out  WID; req_pc  out  PC_WIDTH  fetch request to ifetch.
REQ-011 done_valid / done_warp / done_exit / done_redirect / done_pc  in  1 / WID / 1 / 1 / PC_WIDTH  fetch completion from decode.
REQ-012 active_mask  out  NUM_WARPS  bit i high when warp i is not IDLE.

Function
REQ-013 Each warp SHALL hold state IDLE, READY or ISSUED plus a PC register.
REQ-014 act_valid on IDLE warp SHALL set READY, PC = act_pc, age = 0; act on non-IDLE warp SHALL be ignored.
REQ-015 A warp SHALL go READY->ISSUED in the cycle it is loaded into the request register.
REQ-016 done_valid on ISSUED warp: done_exit -> IDLE; else READY with PC = done_redirect ? done_pc : PC+4 (mod 2^PC_WIDTH).
REQ-017 done_valid on a warp not ISSUED SHALL be ignored.
REQ-018 act and done for the same warp in one cycle: done applies, act ignored.
REQ-019 Request register SHALL load when empty or on handshake (req_valid & req_ready) in that cycle.
REQ-020 When loading with no READY warp, req_valid SHALL go low.
REQ-021 While req_valid & !req_ready, req_valid/req_warp/req_pc SHALL stay stable.
REQ-022 Latency: act at cycle t SHALL give req_valid at t+1 at earliest; done at t allows reselection at t+1.
REQ-023 Round-robin: search SHALL start at (last granted + 1) mod NUM_WARPS, first READY wins.
REQ-024 GTO: last granted warp SHALL win if READY; otherwise the READY warp with largest age; ties to lowest index.
REQ-025 Age counters SHALL increment each cycle while warp non-IDLE, saturating at 2^AGE_WIDTH-1.
REQ-026 With rdy low, no state, counter or output SHALL change; no handshake, act or done SHALL be consumed.

Reset
REQ-027 On rst_n low, asynchronously: all warps IDLE, PCs 0, ages 0, req_valid 0, req_warp 0, req_pc 0, active_mask 0, last-grant 0.
REQ-028 Reset mid-request SHALL drop the outstanding request; no completion SHALL be required afterwards.

Structure
REQ-029 warp_state_e enum and SCHED_RR / SCHED_GTO constants SHALL live in package gelato_frontend_pkg.
REQ-030 Selection SHALL be one combinational sub-module, gelato_warp_picker (ready mask, base index, priority mask -> grant, grant_valid).

Verification
REQ-031 Activate warps 0,3,5 at PC 0x100/0x200/0x300, req_ready=1, RR -> grants 0,3,5,0 only as each done arrives; PCs 0x104 etc.
REQ-032 Hold req_ready=0 five cycles with warp 2 granted, activate warp 1 -> req_warp=2, req_pc unchanged until handshake.
REQ-033 GTO: warps 1 (older) and 4 READY, warp 4 last granted and done -> warp 4 regranted; warp 4 exits -> warp 1 granted.
REQ-034 done_redirect=1, done_pc=0x4000 for warp 6 -> next req_pc 0x4000; PC 0xFFFFFFFC done -> 0x00000000.
REQ-035 Same-cycle act and done(exit) on warp 3 -> warp 3 IDLE, active_mask[3]=0; act on READY warp ignored.
REQ-036 rdy low 3 cycles with done_valid and req_ready high -> no state change; assert rst_n low mid-request -> all outputs 0 next edge.

Source files
------------

// File: rtl/gelato_frontend_pkg.sv
// Shared types and constants for the gelato fetch front end.
package gelato_frontend_pkg;

  typedef enum logic [1:0] {
    WARP_IDLE   = 2'd0,
    WARP_READY  = 2'd1,
    WARP_ISSUED = 2'd2
  } warp_state_e;

  localparam int unsigned SCHED_RR  = 0;
  localparam int unsigned SCHED_GTO = 1;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/gelato_warp_picker.sv
// Rotating-priority pick among warps that are both ready and prioritised,
// searching upward from base_i with wrap-around.
module gelato_warp_picker
  import gelato_frontend_pkg::*;
#(
  parameter  int unsigned NUM_WARPS = 8,
  localparam int unsigned WID       = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] ready_i,
  input  logic [WID-1:0]       base_i,
  input  logic [NUM_WARPS-1:0] prio_i,
  output logic [WID-1:0]       grant_o,
  output logic                 grant_valid_o
);

  logic [NUM_WARPS-1:0] cand;
  logic [WID-1:0]       idx;

  always_comb begin
    cand          = ready_i & prio_i;
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int unsigned k = 0; k < NUM_WARPS; k++) begin
      // NUM_WARPS is a power of two, so WID-bit truncation is the modulo.
      idx = base_i + WID'(k);
      if (!grant_valid_o && cand[idx]) begin
        grant_o       = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gelato_fetch_arbiter.sv
// Per-warp fetch state tracking and selection of the next warp to fetch,
// presented through a single stallable request register.
module gelato_fetch_arbiter
  import gelato_frontend_pkg::*;
#(
  parameter  int unsigned NUM_WARPS  = 8,
  parameter  int unsigned PC_WIDTH   = 32,
  parameter  int unsigned SCHED_MODE = 0,
  parameter  int unsigned AGE_WIDTH  = 8,
  localparam int unsigned WID        = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 act_valid,
  input  logic [WID-1:0]       act_warp,
  input  logic [PC_WIDTH-1:0]  act_pc,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [WID-1:0]       req_warp,
  output logic [PC_WIDTH-1:0]  req_pc,
  input  logic                 done_valid,
  input  logic [WID-1:0]       done_warp,
  input  logic                 done_exit,
  input  logic                 done_redirect,
  input  logic [PC_WIDTH-1:0]  done_pc,
  output logic [NUM_WARPS-1:0] active_mask
);

  warp_state_e          state_q [NUM_WARPS];
  warp_state_e          state_d [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_q    [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_d    [NUM_WARPS];
  logic [AGE_WIDTH-1:0] age_q   [NUM_WARPS];
  logic [AGE_WIDTH-1:0] age_d   [NUM_WARPS];

  logic                 req_valid_q, req_valid_d;
  logic [WID-1:0]       req_warp_q,  req_warp_d;
  logic [PC_WIDTH-1:0]  req_pc_q,    req_pc_d;
  logic [WID-1:0]       last_q,      last_d;

  logic [NUM_WARPS-1:0] ready_mask;
  logic [NUM_WARPS-1:0] active;
  logic [NUM_WARPS-1:0] prio;
  logic [WID-1:0]       base;
  logic [AGE_WIDTH-1:0] max_age;
  logic [WID-1:0]       grant;
  logic                 grant_valid;
  logic                 load;
  logic                 act_take;
  logic                 done_take;

  always_comb begin
    ready_mask = '0;
    active     = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      ready_mask[i] = (state_q[i] == WARP_READY);
      active[i]     = (state_q[i] != WARP_IDLE);
    end
  end

  // GTO narrows the candidate set (sticky warp, else the oldest) and lets the
  // picker break ties from index 0; RR opens every warp and rotates the base.
  always_comb begin
    max_age = '0;
    prio    = '0;
    base    = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (ready_mask[i] && (age_q[i] > max_age)) begin
        max_age = age_q[i];
      end
    end
    if (SCHED_MODE == SCHED_GTO) begin
      if (ready_mask[last_q]) begin
        prio[last_q] = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
          prio[i] = (age_q[i] == max_age);
        end
      end
    end else begin
      prio = '1;
      base = last_q + WID'(1);
    end
  end

  gelato_warp_picker #(
    .NUM_WARPS (NUM_WARPS)
  ) u_picker (
    .ready_i       (ready_mask),
    .base_i        (base),
    .prio_i        (prio),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign load      = rdy && (!req_valid_q || req_ready);
  assign done_take = done_valid && (state_q[done_warp] == WARP_ISSUED);
  assign act_take  = act_valid && (state_q[act_warp] == WARP_IDLE) &&
                     !(done_valid && (done_warp == act_warp));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    age_d       = age_q;
    req_valid_d = req_valid_q;
    req_warp_d  = req_warp_q;
    req_pc_d    = req_pc_q;
    last_d      = last_q;
    if (rdy) begin
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        if ((state_q[i] != WARP_IDLE) && (age_q[i] != '1)) begin
          age_d[i] = age_q[i] + AGE_WIDTH'(1);
        end
      end
      if (act_take) begin
        state_d[act_warp] = WARP_READY;
        pc_d[act_warp]    = act_pc;
        age_d[act_warp]   = '0;
      end
      if (done_take) begin
        if (done_exit) begin
          state_d[done_warp] = WARP_IDLE;
        end else begin
          state_d[done_warp] = WARP_READY;
          pc_d[done_warp]    = done_redirect ? done_pc
                                             : pc_q[done_warp] + PC_WIDTH'(PC_STEP);
        end
      end
      // The granted warp is READY, so act/done above never touch it.
      if (load) begin
        req_valid_d = grant_valid;
        if (grant_valid) begin
          req_warp_d     = grant;
          req_pc_d       = pc_q[grant];
          state_d[grant] = WARP_ISSUED;
          last_d         = grant;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= WARP_IDLE;
        pc_q[i]    <= '0;
        age_q[i]   <= '0;
      end
      req_valid_q <= 1'b0;
      req_warp_q  <= '0;
      req_pc_q    <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      age_q       <= age_d;
      req_valid_q <= req_valid_d;
      req_warp_q  <= req_warp_d;
      req_pc_q    <= req_pc_d;
      last_q      <= last_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_warp    = req_warp_q;
  assign req_pc      = req_pc_q;
  assign active_mask = active;

endmodule

// File: tb/tb_gelato_fetch_arbiter.sv
// Directed and randomized checks of gelato_fetch_arbiter in RR and GTO modes
// against a cycle-level reference model of the warp/request rules.
module tb_gelato_fetch_arbiter;

  localparam int NW = 8;
  localparam int S_IDLE = 0, S_READY = 1, S_ISSUED = 2;

  logic clk, rst_n;
  logic [1:0]       rdy, act_valid, req_ready, done_valid, done_exit, done_redirect, rv;
  logic [1:0][2:0]  act_warp, done_warp, rw;
  logic [1:0][31:0] act_pc, done_pc, rp;
  logic [1:0][7:0]  am;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  int          m_st   [2][NW];
  logic [31:0] m_pc   [2][NW];
  int          m_age  [2][NW];
  bit          m_rv   [2];
  int          m_rw   [2];
  logic [31:0] m_rp   [2];
  int          m_last [2];

  gelato_fetch_arbiter #(
    .NUM_WARPS (8), .PC_WIDTH (32), .SCHED_MODE (0), .AGE_WIDTH (8)
  ) u_rr (
    .clk (clk), .rst_n (rst_n), .rdy (rdy[0]),
    .act_valid (act_valid[0]), .act_warp (act_warp[0]), .act_pc (act_pc[0]),
    .req_valid (rv[0]), .req_ready (req_ready[0]), .req_warp (rw[0]), .req_pc (rp[0]),
    .done_valid (done_valid[0]), .done_warp (done_warp[0]), .done_exit (done_exit[0]),
    .done_redirect (done_redirect[0]), .done_pc (done_pc[0]), .active_mask (am[0])
  );

  gelato_fetch_arbiter #(
    .NUM_WARPS (8), .PC_WIDTH (32), .SCHED_MODE (1), .AGE_WIDTH (4)
  ) u_gto (
    .clk (clk), .rst_n (rst_n), .rdy (rdy[1]),
    .act_valid (act_valid[1]), .act_warp (act_warp[1]), .act_pc (act_pc[1]),
    .req_valid (rv[1]), .req_ready (req_ready[1]), .req_warp (rw[1]), .req_pc (rp[1]),
    .done_valid (done_valid[1]), .done_warp (done_warp[1]), .done_exit (done_exit[1]),
    .done_redirect (done_redirect[1]), .done_pc (done_pc[1]), .active_mask (am[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < NW; w++) begin
        m_st[d][w] = S_IDLE; m_pc[d][w] = '0; m_age[d][w] = 0;
      end
      m_rv[d] = 1'b0; m_rw[d] = 0; m_rp[d] = '0; m_last[d] = 0;
    end
  endfunction

  function automatic void model_step(input int d);
    int g, best, aw, dw, amax;
    bit ld;
    if (!rdy[d]) return;
    amax = (d == 0) ? 255 : 15;
    g  = -1;
    ld = !m_rv[d] || req_ready[d];
    if (ld) begin
      if (d == 0) begin
        for (int k = 1; k <= NW; k++) begin
          int w;
          w = (m_last[d] + k) % NW;
          if (g < 0 && m_st[d][w] == S_READY) g = w;
        end
      end else if (m_st[d][m_last[d]] == S_READY) begin
        g = m_last[d];
      end else begin
        best = -1;
        for (int w = 0; w < NW; w++)
          if (m_st[d][w] == S_READY && m_age[d][w] > best) begin
            g = w; best = m_age[d][w];
          end
      end
    end
    for (int w = 0; w < NW; w++)
      if (m_st[d][w] != S_IDLE && m_age[d][w] < amax) m_age[d][w]++;
    aw = int'(act_warp[d]);
    dw = int'(done_warp[d]);
    if (act_valid[d] && m_st[d][aw] == S_IDLE && !(done_valid[d] && dw == aw)) begin
      m_st[d][aw] = S_READY; m_pc[d][aw] = act_pc[d]; m_age[d][aw] = 0;
    end
    if (done_valid[d] && m_st[d][dw] == S_ISSUED) begin
      if (done_exit[d]) m_st[d][dw] = S_IDLE;
      else begin
        m_st[d][dw] = S_READY;
        m_pc[d][dw] = done_redirect[d] ? done_pc[d] : m_pc[d][dw] + 32'd4;
      end
    end
    if (ld) begin
      m_rv[d] = (g >= 0);
      if (g >= 0) begin
        m_rw[d] = g; m_rp[d] = m_pc[d][g]; m_st[d][g] = S_ISSUED; m_last[d] = g;
      end
    end
  endfunction

  task automatic compare(input int d);
    logic [7:0] em;
    em = '0;
    for (int w = 0; w < NW; w++) em[w] = (m_st[d][w] != S_IDLE);
    chk($sformatf("d%0d_req_valid", d), 64'(rv[d]), 64'(m_rv[d]));
    if (m_rv[d]) begin
      chk($sformatf("d%0d_req_warp", d), 64'(rw[d]), 64'(m_rw[d]));
      chk($sformatf("d%0d_req_pc", d), 64'(rp[d]), 64'(m_rp[d]));
    end
    chk($sformatf("d%0d_active_mask", d), 64'(am[d]), 64'(em));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_valid", tag, d), 64'(rv[d]), 64'd0);
      chk($sformatf("%s_d%0d_warp", tag, d), 64'(rw[d]), 64'd0);
      chk($sformatf("%s_d%0d_pc", tag, d), 64'(rp[d]), 64'd0);
      chk($sformatf("%s_d%0d_mask", tag, d), 64'(am[d]), 64'd0);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_zero({tag, "_async"});
    @(posedge clk);
    #1;
    chk_zero({tag, "_edge"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic quiet(input int d);
    act_valid[d] = 1'b0; done_valid[d] = 1'b0;
    done_exit[d] = 1'b0; done_redirect[d] = 1'b0;
  endtask

  task automatic set_act(input int d, input int w, input logic [31:0] pc);
    act_valid[d] = 1'b1; act_warp[d] = 3'(w); act_pc[d] = pc;
  endtask

  task automatic set_done(input int d, input int w, input bit ex, input bit rd,
                          input logic [31:0] pc);
    done_valid[d] = 1'b1; done_warp[d] = 3'(w);
    done_exit[d] = ex; done_redirect[d] = rd; done_pc[d] = pc;
  endtask

  task automatic chk_req(input int d, input string tag, input int w, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(rv[d]), 64'd1);
    chk({tag, "_warp"}, 64'(rw[d]), 64'(w));
    chk({tag, "_pc"}, 64'(rp[d]), 64'(pc));
  endtask

  initial begin
    rst_n = 1'b0;
    act_warp = '0; act_pc = '0; done_warp = '0; done_pc = '0;
    for (int d = 0; d < 2; d++) begin
      rdy[d] = 1'b1; req_ready[d] = 1'b1; quiet(d);
    end
    do_reset("por");

    // Round-robin grants follow activation order, then re-grant only on done.
    set_act(0, 0, 32'h100); tick();
    set_act(0, 3, 32'h200); tick(); chk_req(0, "rr_g0", 0, 32'h100);
    set_act(0, 5, 32'h300); tick(); chk_req(0, "rr_g3", 3, 32'h200);
    quiet(0); tick(); chk_req(0, "rr_g5", 5, 32'h300);
    tick(); chk("rr_no_ready", 64'(rv[0]), 64'd0);
    set_done(0, 0, 0, 0, 0); tick(); chk("rr_done_lat", 64'(rv[0]), 64'd0);
    quiet(0); tick(); chk_req(0, "rr_g0_again", 0, 32'h104);
    set_done(0, 3, 0, 0, 0); tick();
    quiet(0); tick(); chk_req(0, "rr_g3_again", 3, 32'h204);

    // Stalled request holds while another warp becomes ready.
    do_reset("rst_stall");
    req_ready[0] = 1'b0; set_act(0, 2, 32'h220); tick();
    quiet(0); tick(); chk_req(0, "stall_load", 2, 32'h220);
    set_act(0, 1, 32'h110);
    for (int i = 0; i < 5; i++) begin
      tick(); quiet(0); chk_req(0, "stall_hold", 2, 32'h220);
    end
    req_ready[0] = 1'b1; tick(); chk_req(0, "stall_release", 1, 32'h110);

    // GTO: sticky warp beats an older ready warp until it exits.
    do_reset("rst_gto");
    set_act(1, 1, 32'h140); tick();
    set_act(1, 4, 32'h400); tick(); chk_req(1, "gto_first", 1, 32'h140);
    quiet(1); tick(); chk_req(1, "gto_w4", 4, 32'h400);
    req_ready[1] = 1'b0; set_done(1, 1, 0, 0, 0); tick();
    set_done(1, 4, 0, 0, 0); tick();
    quiet(1); req_ready[1] = 1'b1; tick(); chk_req(1, "gto_greedy", 4, 32'h404);
    req_ready[1] = 1'b0; set_done(1, 4, 1, 0, 0); tick();
    chk("gto_exit_mask", 64'(am[1][4]), 64'd0);
    quiet(1); req_ready[1] = 1'b1; tick(); chk_req(1, "gto_after_exit", 1, 32'h144);

    // Redirect and PC wrap.
    do_reset("rst_redir");
    set_act(0, 6, 32'h600); tick();
    quiet(0); tick(); chk_req(0, "redir_first", 6, 32'h600);
    set_done(0, 6, 0, 1, 32'h4000); tick();
    quiet(0); tick(); chk_req(0, "redir_pc", 6, 32'h4000);
    set_act(0, 7, 32'hFFFF_FFFC); tick();
    quiet(0); tick(); chk_req(0, "wrap_first", 7, 32'hFFFF_FFFC);
    set_done(0, 7, 0, 0, 0); tick();
    quiet(0); tick(); chk_req(0, "wrap_pc", 7, 32'h0);

    // Same-cycle act+exit, and act on a READY warp.
    do_reset("rst_same");
    set_act(0, 3, 32'h300); tick();
    quiet(0); tick(); chk_req(0, "same_first", 3, 32'h300);
    set_done(0, 3, 1, 0, 0); set_act(0, 3, 32'h999); tick();
    chk("same_exit_mask", 64'(am[0][3]), 64'd0);
    quiet(0); tick();
    chk("same_act_dropped", 64'(am[0][3]), 64'd0);
    chk("same_no_req", 64'(rv[0]), 64'd0);
    req_ready[0] = 1'b0; set_act(0, 2, 32'h200); tick();
    quiet(0); tick(); chk_req(0, "ign_pend", 2, 32'h200);
    set_act(0, 5, 32'h500); tick();
    set_act(0, 5, 32'h555); tick();
    quiet(0); req_ready[0] = 1'b1; tick(); chk_req(0, "ign_act", 5, 32'h500);

    // rdy low freezes everything; reset drops an outstanding request.
    do_reset("rst_frz");
    req_ready[0] = 1'b0; set_act(0, 1, 32'h100); tick();
    quiet(0); tick(); chk_req(0, "frz_pend", 1, 32'h100);
    rdy[0] = 1'b0; req_ready[0] = 1'b1;
    set_done(0, 1, 1, 0, 0); set_act(0, 6, 32'h660);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_req(0, "frz_hold", 1, 32'h100);
      chk("frz_mask", 64'(am[0]), 64'h02);
    end
    rdy[0] = 1'b1; quiet(0); req_ready[0] = 1'b0; tick();
    chk_req(0, "frz_resume", 1, 32'h100);
    do_reset("rst_mid");

    // Randomized traffic on both instances, with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        rdy[d]           = ($urandom % 10) != 0;
        req_ready[d]     = ($urandom % 3) != 0;
        act_valid[d]     = ($urandom % 3) == 0;
        act_warp[d]      = 3'($urandom % 8);
        act_pc[d]        = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        done_valid[d]    = ($urandom % 2) == 0;
        done_warp[d]     = 3'($urandom % 8);
        done_exit[d]     = ($urandom % 5) == 0;
        done_redirect[d] = ($urandom % 4) == 0;
        done_pc[d]       = $urandom & 32'hFFFF_FFFC;
      end
      tick();
      if (c % 500 == 499) do_reset("rst_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
